bg_fetch_sequencer: RTL
=======================

// Module: bg_fetch_sequencer
// PURPOSE
//  Sequences the background tile fetch for one scanline. Drives the byte-capture strobes and
//  pipe load/shift of the BG pixel shifter:
//   - latch_lo: low-plane latch enable
//   - latch_hi: high-plane register clock
//   - load_pipe: parallel load
//   - shift_en: pipe clock enable
//  Sits between PPU mode/scroll control and the VRAM read path. Counts emitted pixels, discards
//  the fine-scroll prefix and reports end of line.
// PARAMETERS
//  LINE_PIXELS  160  visible pixels per line; line ends after this many valid pixels
//  TILE_X_W     5    width of tile column counter (32-tile map row)
// PORTS
//  clk           in   1  dot clock; all state updates on rising edge
//  reset         in   1  synchronous, active-high; wins over every other input
//  line_start    in   1  one-cycle pulse: begin fetching a new line
//  win_trigger   in   1  one-cycle pulse: restart fetch from window map
//  sprite_stall  in   1  level: freeze fetcher, pipe and all counters
//  scx_fine      in   3  pixels to discard at line start, sampled on line_start
//  vram_rd       out  1  VRAM read request, high during fetch states
//  fetch_kind    out  2  0=TILE index, 1=DATA_LO, 2=DATA_HI; 0 when vram_rd low
//  fetch_win     out  1  current fetches address the window map
//  tile_x        out  TILE_X_W  current tile column
//  latch_lo      out  1  one-cycle strobe: capture low plane byte from md
//  latch_hi      out  1  one-cycle strobe: capture high plane byte from md
//  load_pipe     out  1  one-cycle strobe: parallel-load both planes into pipe
//  shift_en      out  1  shift pipe one pixel this cycle
//  pix_valid     out  1  pixel at pipe output goes to LCD this cycle
//  pix_x         out  8  index of next pixel to emit
//  line_done     out  1  one-cycle pulse when line completes
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; pipe_cnt=0, discard=0.
//  - States: IDLE, T0, T1, L0, L1, H0, H1, WAIT. Each fetch step takes 2 cycles.
//  - IDLE -> T0 on line_start.
//  - Fetch chain: T0->T1->L0->L1->H0->H1, one state per cycle when not stalled.
//  - vram_rd=1 in T0..H1, with fetch_kind set per state.
//  - latch_lo=1 in L1 only; latch_hi=1 in H1 only.
//  - H1 or WAIT with pipe_cnt==0:
//    - assert load_pipe; pipe_cnt<=8; tile_x<=tile_x+1 (wraps 31->0); next state T0.
//  - H1 or WAIT with pipe_cnt!=0: next state WAIT.
//  - shift_en = (pipe_cnt!=0) && !sprite_stall && state!=IDLE. On shift, pipe_cnt decrements.
//    - load_pipe and shift_en are never high in the same cycle.
//    - This costs a one-cycle bubble per tile; the bubble is intended.
//  - pix_valid = shift_en && discard==0.
//    - Shift with discard!=0: discard decrements, pix_x holds.
//    - Valid pixel: pix_x increments.
//  - line_done: after the shift with pix_valid at pix_x==LINE_PIXELS-1:
//    - next cycle line_done=1 for one cycle, state IDLE, all strobes 0, pipe_cnt=0.
//  - line_start, from any state:
//    - pipe_cnt=0, pix_x=0, tile_x=0, fetch_win=0, discard=scx_fine, state T0.
//  - win_trigger (state != IDLE):
//    - pipe_cnt=0, tile_x=0, fetch_win=1, state T0.
//    - pix_x and discard are kept; no strobes that cycle.
//  - line_start and win_trigger in the same cycle: line_start wins.
//  - win_trigger in IDLE is ignored.
//  - sprite_stall=1:
//    - state and counters hold; vram_rd, latch_*, load_pipe, shift_en, pix_valid all 0.
//    - Resumes where it left off.
//    - A stall in L1/H1 delays the strobe until the first unstalled cycle.
//  - reset mid-line: returns to IDLE next edge; no line_done.
// STRUCTURE
//  - Package ppu_fetch_pkg:
//    - fetch_state_t enum (IDLE,T0,T1,L0,L1,H0,H1,WAIT)
//    - fetch_kind_t enum (KIND_TILE=0, KIND_LO=1, KIND_HI=2)
//    - PIPE_DEPTH=8 constant
//  - One sub-module bg_pipe_occupancy: holds pipe_cnt, discard and pix_x; generates shift_en,
//    pix_valid and the done condition.
//  - The FSM stays in the top module.
// TESTING
//  - Line, no scroll: reset, line_start with scx_fine=0. Required response:
//    - vram_rd kinds 0,0,1,1,2,2 in cycles 1-6
//    - latch_lo in cycle 4, latch_hi in cycle 6, load_pipe in cycle 6
//    - 8 pix_valid in cycles 7-14
//  - Full line: line_start with scx_fine=0. Required response:
//    - exactly 160 pix_valid pulses, then line_done
//    - load_pipe count 21, tile_x=21 at end, state IDLE
//  - Fine scroll: line_start with scx_fine=5. Required response:
//    - first 5 shifts have pix_valid=0; pix_x reaches 160 after 165 shifts
//  - Stall: sprite_stall held 6 cycles in state L1. Required response:
//    - latch_lo delayed exactly 6 cycles; no shift_en during the stall; total pixels still 160
//  - Window: win_trigger at pix_x=80. Required response:
//    - pipe flushed, fetch_win=1, tile_x=0, next load after 6 fetch cycles
//    - pix_x continues from 80
//  - Collisions: line_start and win_trigger together -> fetch_win=0.
//    reset at pix_x=50 -> all outputs 0 next cycle, no line_done.

Source files
------------

// File: rtl/ppu_fetch_pkg.sv
// Shared types and constants for the background fetch sequencer.
//   fetch_state_t : fetcher FSM states (two cycles per fetch step)
//   fetch_kind_t  : which VRAM byte the current read returns
//   PIPE_DEPTH    : pixels held by the BG shifter after a parallel load
package ppu_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    L0   = 3'd3,
    L1   = 3'd4,
    H0   = 3'd5,
    H1   = 3'd6,
    WAIT = 3'd7
  } fetch_state_t;

  typedef enum logic [1:0] {
    KIND_TILE = 2'd0,
    KIND_LO   = 2'd1,
    KIND_HI   = 2'd2
  } fetch_kind_t;

  localparam int PIPE_DEPTH = 8;

endpackage

// File: rtl/bg_pipe_occupancy.sv
// Occupancy tracking for the BG pixel pipe.
// Holds how many pixels remain in the pipe, how many fine-scroll pixels
// still have to be thrown away, and the index of the next pixel to emit.
// Ports:
//   clk, reset    : dot clock, synchronous active-high reset
//   line_start    : clear everything and take a new scx_fine discard count
//   flush         : empty the pipe (window restart or end of line)
//   load          : pipe is being parallel-loaded this cycle
//   active        : fetcher is running this cycle (not idle, stalled or restarting)
//   scx_fine      : number of pixels to discard at the start of the line
//   shift_en      : pipe shifts one pixel this cycle
//   pix_valid     : shifted pixel is sent to the LCD
//   pix_x         : index of the next pixel to emit
//   pipe_empty    : no pixels left in the pipe
//   line_full     : every visible pixel of the line has been emitted
module bg_pipe_occupancy
  import ppu_fetch_pkg::*;
#(
  parameter int LINE_PIXELS = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic       flush,
  input  logic       load,
  input  logic       active,
  input  logic [2:0] scx_fine,
  output logic       shift_en,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic       pipe_empty,
  output logic       line_full
);

  logic [3:0] pipe_cnt;
  logic [2:0] discard;

  assign pipe_empty = (pipe_cnt == 4'd0);
  assign line_full  = (pix_x == 8'(LINE_PIXELS));
  // Once the last visible pixel is out, the pipe stops shifting even though
  // the fetcher may still be finishing the tile it already started.
  assign shift_en   = active && !pipe_empty && !line_full;
  assign pix_valid  = shift_en && (discard == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_cnt <= 4'd0;
      discard  <= 3'd0;
      pix_x    <= 8'd0;
    end else if (line_start) begin
      pipe_cnt <= 4'd0;
      discard  <= scx_fine;
      pix_x    <= 8'd0;
    end else if (flush) begin
      pipe_cnt <= 4'd0;
    end else if (load) begin
      pipe_cnt <= 4'(PIPE_DEPTH);
    end else if (shift_en) begin
      pipe_cnt <= pipe_cnt - 4'd1;
      if (discard != 3'd0) begin
        discard <= discard - 3'd1;
      end else begin
        pix_x <= pix_x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/bg_fetch_sequencer.sv
// Background tile fetch sequencer for one scanline.
// Walks the tile-index / low-plane / high-plane VRAM reads, strobes the byte
// latches, loads the BG pixel pipe when it runs empty and reports end of line.
// Ports:
//   clk, reset    : dot clock, synchronous active-high reset
//   line_start    : pulse, begin a new line (wins over win_trigger)
//   win_trigger   : pulse, restart fetching from the window map (ignored in IDLE)
//   sprite_stall  : level, freeze fetcher, pipe and counters
//   scx_fine      : fine-scroll pixels to discard, sampled on line_start
//   vram_rd       : VRAM read request during fetch states
//   fetch_kind    : 0 tile index, 1 low plane, 2 high plane (0 when idle)
//   fetch_win     : fetches address the window map
//   tile_x        : current tile column
//   latch_lo/hi   : capture low/high plane byte
//   load_pipe     : parallel-load both planes into the pipe
//   shift_en      : pipe shifts one pixel
//   pix_valid     : pixel goes to the LCD
//   pix_x         : index of next pixel to emit
//   line_done     : one-cycle pulse when the line completes
//   state         : current fetcher state, for observation
//
// Handshake: there is no backpressure; every strobe is a single-cycle
// qualifier valid only in the cycle it is high, and sprite_stall forces all
// of them low while leaving state untouched so the sequence resumes intact.
module bg_fetch_sequencer
  import ppu_fetch_pkg::*;
#(
  parameter int LINE_PIXELS = 160,
  parameter int TILE_X_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic                win_trigger,
  input  logic                sprite_stall,
  input  logic [2:0]          scx_fine,
  output logic                vram_rd,
  output logic [1:0]          fetch_kind,
  output logic                fetch_win,
  output logic [TILE_X_W-1:0] tile_x,
  output logic                latch_lo,
  output logic                latch_hi,
  output logic                load_pipe,
  output logic                shift_en,
  output logic                pix_valid,
  output logic [7:0]          pix_x,
  output logic                line_done,
  output fetch_state_t        state
);

  logic        win_accept;
  logic        done_now;
  logic        run;
  logic        pipe_empty;
  logic        line_full;
  fetch_kind_t kind;

  // A window restart after the last pixel would re-arm a finished line, so
  // it is only honoured while pixels are still owed.
  assign win_accept = win_trigger && (state != IDLE) && !line_full;
  // The line closes in the first unstalled cycle after the final pixel.
  // Fetching still runs in that cycle, so a tile that is ready gets loaded.
  assign done_now   = (state != IDLE) && line_full && !sprite_stall && !line_start;
  assign run        = (state != IDLE) && !sprite_stall && !line_start && !win_accept;

  always_comb begin
    vram_rd   = 1'b0;
    kind      = KIND_TILE;
    latch_lo  = 1'b0;
    latch_hi  = 1'b0;
    load_pipe = 1'b0;
    if (run) begin
      case (state)
        T0, T1: vram_rd = 1'b1;
        L0: begin
          vram_rd = 1'b1;
          kind    = KIND_LO;
        end
        L1: begin
          vram_rd  = 1'b1;
          kind     = KIND_LO;
          latch_lo = 1'b1;
        end
        H0: begin
          vram_rd = 1'b1;
          kind    = KIND_HI;
        end
        H1: begin
          vram_rd   = 1'b1;
          kind      = KIND_HI;
          latch_hi  = 1'b1;
          load_pipe = pipe_empty;
        end
        WAIT: load_pipe = pipe_empty;
        default: ;
      endcase
    end
  end

  assign fetch_kind = kind;

  always_ff @(posedge clk) begin
    line_done <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      tile_x    <= '0;
      fetch_win <= 1'b0;
    end else if (line_start) begin
      state     <= T0;
      tile_x    <= '0;
      fetch_win <= 1'b0;
    end else if (done_now) begin
      state     <= IDLE;
      line_done <= 1'b1;
      if (load_pipe) begin
        tile_x <= tile_x + 1'b1;
      end
    end else if (win_accept) begin
      state     <= T0;
      tile_x    <= '0;
      fetch_win <= 1'b1;
    end else if (!sprite_stall) begin
      case (state)
        T0: state <= T1;
        T1: state <= L0;
        L0: state <= L1;
        L1: state <= H0;
        H0: state <= H1;
        H1, WAIT: begin
          if (pipe_empty) begin
            state  <= T0;
            tile_x <= tile_x + 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bg_pipe_occupancy #(
    .LINE_PIXELS(LINE_PIXELS)
  ) u_occupancy (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .flush      (win_accept || done_now),
    .load       (load_pipe),
    .active     (run),
    .scx_fine   (scx_fine),
    .shift_en   (shift_en),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pipe_empty (pipe_empty),
    .line_full  (line_full)
  );

endmodule
